gpu_op_queue: RTL and testbench
===============================

Name: gpu_op_queue

Overview:
- Parametrised op buffer between the game CPU and the GPU.
- The CPU writes ops speculatively during a frame. They become visible to the GPU only when the frame is committed, and can be discarded by rollback (for example, a frame aborted on lose).
- Successor to the plain op FIFO: adds configurable width, depth and almost-full threshold, plus a commit/rollback mode.
- The write side matches the existing CPU op port, so `full` maps to `op_full`.

Parameters:
- DATA_W, 32, op word width; set to $bits(gpu_op_t) at instantiation.
- DEPTH, 16, entries; must be a power of two, ≥4.
- ALMOST_FULL, 4, `almost_full` asserts when free slots ≤ this value; range 0..DEPTH-1.
- COMMIT_MODE, 1, 1 = frame commit/rollback enabled; 0 = plain FIFO, `commit`/`rollback` ignored.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- ce, input, 1, clock enable; when low all state holds and every request is ignored.
- wr_data, input, DATA_W, op word to write.
- wr_en, input, 1, write request.
- full, output, 1, no free slot.
- almost_full, output, 1, free slots ≤ ALMOST_FULL.
- commit, input, 1, publish all written ops, including a write in the same cycle.
- rollback, input, 1, discard all uncommitted ops.
- rd_data, output, DATA_W, head of committed data, first-word-fall-through.
- rd_en, input, 1, pop the head.
- empty, output, 1, no committed word available.
- committed_count, output, $clog2(DEPTH)+1, committed words not yet read.
- overflow, output, 1, sticky: write attempted while full.
- underflow, output, 1, sticky: read attempted while empty.

Behaviour:
- **Pointers.** Three pointers of width $clog2(DEPTH)+1 with a wrap bit: wr_ptr (speculative), cmt_ptr (committed), rd_ptr. Ordering is always rd_ptr ≤ cmt_ptr ≤ wr_ptr, modulo 2·DEPTH.
- **Reset.** All pointers 0. Output values: full=0, almost_full=(DEPTH≤ALMOST_FULL)=0, empty=1, committed_count=0, overflow=0, underflow=0. rd_data is don't-care while empty. Reset mid-frame discards all data, committed or not.
- **Derived values.** used = wr_ptr−rd_ptr; full = (used==DEPTH); almost_full = (DEPTH−used ≤ ALMOST_FULL); committed_count = cmt_ptr−rd_ptr; empty = (committed_count==0). All are registered-pointer functions, so they update the cycle after the causing edge.
- **Write.** On ce & wr_en & !full, store at mem[wr_ptr] and increment wr_ptr.
  - wr_en while full: word dropped, overflow←1 until reset.
  - `full` is pre-edge state: a simultaneous read does not make room for that cycle's write.
- **Read.** rd_data = mem[rd_ptr] combinationally.
  - On ce & rd_en & !empty, increment rd_ptr.
  - rd_en while empty: ignored, underflow←1. A word committed in the same cycle is not readable until the next cycle.
- **Commit (COMMIT_MODE=1).** On ce & commit & !rollback, cmt_ptr ← wr_ptr after this cycle's write, so a word written with commit is included.
  - Latency: write+commit at edge N → empty=0 after edge N.
  - Commit with nothing pending is a no-op.
- **Rollback (COMMIT_MODE=1).** On ce & rollback, wr_ptr ← cmt_ptr and any same-cycle write is discarded (no overflow flag set for it).
  - rollback+commit in the same cycle: rollback wins.
  - Reads proceed normally in the rollback cycle.
- **Capacity.** Uncommitted data counts against capacity. A frame larger than DEPTH saturates `full`, and the CPU stalls on `op_full` until ops are committed and drained.
- **COMMIT_MODE=0.** cmt_ptr follows wr_ptr on every accepted write; a write at edge N is readable after edge N. commit/rollback have no effect.
- **Wrap-around.** Pointers wrap modulo 2·DEPTH. The full/empty distinction comes from the wrap bit. Behaviour must be continuous across ≥3 full laps.
- **ce low.** Pointers, memory and sticky flags all frozen; outputs remain the functions of the held state.

Test Plan:
- **Reset and basic commit.** Reset, then write 0x11,0x22,0x33 with commit on the third write → empty stays 1 through the writes and drops the following cycle; committed_count=3; reads return 0x11,0x22,0x33 in order, then empty=1.
- **Rollback.** Write 5 words without commit, assert rollback → committed_count=0, used=0, full=0. Then write 0xAA+commit → single read returns 0xAA. Separately, commit and rollback in the same cycle with 2 pending → both discarded.
- **Fill, overflow, almost_full.** DEPTH=16, ALMOST_FULL=4: 12 writes → almost_full=1, full=0; 16 writes → full=1. A 17th write → overflow=1 and the word is lost. Commit, read all 16 → data is the first 16 words and overflow remains 1.
- **Simultaneous read/write at full.** Full and committed, rd_en+wr_en in the same cycle → read pops, write dropped, overflow=1, used=15.
- **Wrap and underflow.** Stream 50 words with commit each cycle while reading every cycle (after the first) → data matches in order across wraps. Then rd_en on empty → underflow=1, rd_ptr unchanged.
- **COMMIT_MODE=0 and ce.** COMMIT_MODE=0: write 0x5 → empty=0 next cycle; rollback has no effect. With ce=0, wr_en/rd_en pulses → no pointer or flag change.

Source files
------------

// File: rtl/gpu_op_queue.sv
// Speculative op queue between CPU and GPU: writes stay invisible to the reader until
// committed, and uncommitted writes can be dropped by rollback. COMMIT_MODE=0 gives a plain FIFO.
module gpu_op_queue #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 4,
    parameter int COMMIT_MODE = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_ce,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_wr_en,
    output logic                     o_full,
    output logic                     o_almost_full,
    input  logic                     i_commit,
    input  logic                     i_rollback,
    output logic [DATA_W-1:0]        o_rd_data,
    input  logic                     i_rd_en,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_committed_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr, r_cmt_ptr, r_rd_ptr;
    logic              r_overflow, r_underflow;

    logic [PW-1:0]     w_used, w_free, w_cmt_cnt;
    logic              w_rb, w_cm, w_wr_acc, w_wr_ovf, w_rd_acc, w_rd_unf;

    assign w_used    = r_wr_ptr - r_rd_ptr;
    assign w_free    = PW'(DEPTH) - w_used;
    assign w_cmt_cnt = r_cmt_ptr - r_rd_ptr;

    assign o_full            = (w_used == PW'(DEPTH));
    assign o_almost_full     = (w_free <= PW'(ALMOST_FULL));
    assign o_committed_count = w_cmt_cnt;
    assign o_empty           = (w_cmt_cnt == '0);
    assign o_rd_data         = r_mem[r_rd_ptr[AW-1:0]];
    assign o_overflow        = r_overflow;
    assign o_underflow       = r_underflow;

    // Rollback swallows a same-cycle write entirely, including its overflow report.
    assign w_rb     = i_ce && (COMMIT_MODE != 0) && i_rollback;
    assign w_cm     = i_ce && (COMMIT_MODE != 0) && i_commit && !i_rollback;
    assign w_wr_acc = i_ce && i_wr_en && !o_full && !w_rb;
    assign w_wr_ovf = i_ce && i_wr_en &&  o_full && !w_rb;
    assign w_rd_acc = i_ce && i_rd_en && !o_empty;
    assign w_rd_unf = i_ce && i_rd_en &&  o_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_cmt_ptr   <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_rb)
                r_wr_ptr <= r_cmt_ptr;
            else if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + 1'b1;

            // Commit publishes the post-write pointer so a write+commit word is included.
            if (COMMIT_MODE == 0) begin
                if (w_wr_acc)
                    r_cmt_ptr <= r_wr_ptr + 1'b1;
            end else if (w_cm) begin
                r_cmt_ptr <= r_wr_ptr + PW'(w_wr_acc);
            end

            if (w_rd_acc)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr_ovf)
                r_overflow <= 1'b1;
            if (w_rd_unf)
                r_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gpu_op_queue.sv
// Randomised and directed bench for gpu_op_queue: a queue-based frame model
// (committed list + pending list) predicts every output after each clock.
module tb_gpu_op_queue;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int AF = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce, wr_en, commit, rollback, rd_en;
    logic [DW-1:0] wr_data;
    logic          full, almost_full, empty, overflow, underflow;
    logic [DW-1:0] rd_data;
    logic [4:0]    ccount;

    logic          b_ce, b_wr_en, b_commit, b_rollback, b_rd_en;
    logic [DW-1:0] b_wr_data, b_rd_data;
    logic          b_full, b_almost_full, b_empty, b_overflow, b_underflow;
    logic [4:0]    b_ccount;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] m_cq[$];
    logic [DW-1:0] m_pq[$];
    bit            m_ovf, m_unf;

    always #5 clk = ~clk;

    gpu_op_queue #(.DATA_W(DW), .DEPTH(DEPTH), .ALMOST_FULL(AF), .COMMIT_MODE(1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_wr_data(wr_data), .i_wr_en(wr_en),
        .o_full(full), .o_almost_full(almost_full), .i_commit(commit), .i_rollback(rollback),
        .o_rd_data(rd_data), .i_rd_en(rd_en), .o_empty(empty), .o_committed_count(ccount),
        .o_overflow(overflow), .o_underflow(underflow));

    gpu_op_queue #(.DATA_W(DW), .DEPTH(DEPTH), .ALMOST_FULL(AF), .COMMIT_MODE(0)) u_fifo (
        .i_clk(clk), .i_rst(rst), .i_ce(b_ce), .i_wr_data(b_wr_data), .i_wr_en(b_wr_en),
        .o_full(b_full), .o_almost_full(b_almost_full), .i_commit(b_commit), .i_rollback(b_rollback),
        .o_rd_data(b_rd_data), .i_rd_en(b_rd_en), .o_empty(b_empty), .o_committed_count(b_ccount),
        .o_overflow(b_overflow), .o_underflow(b_underflow));

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int tot = m_cq.size() + m_pq.size();
        chk("empty", {31'b0, empty}, {31'b0, m_cq.size() == 0});
        chk("full", {31'b0, full}, {31'b0, tot == DEPTH});
        chk("almost_full", {31'b0, almost_full}, {31'b0, (DEPTH - tot) <= AF});
        chk("committed_count", {27'b0, ccount}, DW'(m_cq.size()));
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        chk("underflow", {31'b0, underflow}, {31'b0, m_unf});
        if (m_cq.size() != 0)
            chk("rd_data", rd_data, m_cq[0]);
    endtask

    // One clock on the commit-mode DUT: model the frame rules on pre-edge state, then compare.
    task automatic cyc(input bit c, input bit w, input logic [DW-1:0] d,
                       input bit cm, input bit rb, input bit r);
        bit was_full = (m_cq.size() + m_pq.size()) == DEPTH;
        bit was_empty = (m_cq.size() == 0);
        ce = c; wr_en = w; wr_data = d; commit = cm; rollback = rb; rd_en = r;
        if (c) begin
            if (r) begin
                if (was_empty) m_unf = 1'b1;
                else void'(m_cq.pop_front());
            end
            if (w && !rb) begin
                if (was_full) m_ovf = 1'b1;
                else m_pq.push_back(d);
            end
            if (rb) m_pq.delete();
            else if (cm) begin
                foreach (m_pq[i]) m_cq.push_back(m_pq[i]);
                m_pq.delete();
            end
        end
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ce = 1'b1; wr_en = 1'b0; wr_data = '0; commit = 1'b0; rollback = 1'b0; rd_en = 1'b0;
        b_ce = 1'b1; b_wr_en = 1'b0; b_wr_data = '0; b_commit = 1'b0; b_rollback = 1'b0; b_rd_en = 1'b0;
        m_cq.delete(); m_pq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clk); #1;
        check_all();
        rst = 1'b0;
    endtask

    task automatic bstep(input bit c, input bit w, input logic [DW-1:0] d,
                         input bit cm, input bit rb, input bit r);
        b_ce = c; b_wr_en = w; b_wr_data = d; b_commit = cm; b_rollback = rb; b_rd_en = r;
        @(posedge clk); #1;
        b_ce = 1'b1; b_wr_en = 1'b0; b_commit = 1'b0; b_rollback = 1'b0; b_rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        #2;
        do_reset();

        // basic commit: visible only after the committing write
        cyc(1, 1, 32'h11, 0, 0, 0);
        cyc(1, 1, 32'h22, 0, 0, 0);
        cyc(1, 1, 32'h33, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 1);

        // rollback of 5 pending, then a single committed word
        for (int i = 0; i < 5; i++) cyc(1, 1, 32'h100 + i, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 1, 32'hAA, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 1, 32'h1, 0, 0, 0);
        cyc(1, 1, 32'h2, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, 0);
        cyc(1, 1, 32'h3, 0, 1, 0);

        // fill to full, overflow, commit, drain
        for (int i = 0; i < 17; i++) cyc(1, 1, 32'h200 + i, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 0, 1);

        // simultaneous read+write at full: read pops, write dropped
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1, 1, 32'h300 + i, i == 15, 0, 0);
        cyc(1, 1, 32'hDEAD, 0, 0, 1);
        for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0, 0, 1);

        // streaming across several laps, then underflow
        do_reset();
        for (int i = 0; i < 50; i++) cyc(1, 1, 32'h400 + i, 1, 0, i > 0);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);

        // ce low freezes everything
        cyc(1, 1, 32'h55, 1, 0, 0);
        cyc(1, 1, 32'h66, 0, 0, 0);
        cyc(0, 1, 32'h77, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 1, 32'h88, 0, 0, 0);

        // randomised frames
        do_reset();
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 9) < 6, $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
        do_reset();

        // plain FIFO mode: writes readable next cycle, commit/rollback inert
        bstep(1, 1, 32'h5, 0, 0, 0);
        chk("m0 empty", {31'b0, b_empty}, 32'h0);
        chk("m0 count", {27'b0, b_ccount}, 32'd1);
        chk("m0 data", b_rd_data, 32'h5);
        bstep(1, 0, 0, 0, 1, 0);
        chk("m0 rb count", {27'b0, b_ccount}, 32'd1);
        bstep(1, 1, 32'h6, 1, 1, 0);
        chk("m0 rb+wr count", {27'b0, b_ccount}, 32'd2);
        bstep(0, 1, 32'h7, 0, 0, 1);
        chk("m0 ce count", {27'b0, b_ccount}, 32'd2);
        chk("m0 ce data", b_rd_data, 32'h5);
        bstep(1, 0, 0, 0, 0, 1);
        chk("m0 pop data", b_rd_data, 32'h6);
        bstep(1, 0, 0, 0, 0, 1);
        bstep(1, 0, 0, 0, 0, 1);
        chk("m0 underflow", {31'b0, b_underflow}, 32'h1);
        chk("m0 overflow", {31'b0, b_overflow}, 32'h0);
        chk("m0 empty end", {31'b0, b_empty}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
